// File: rtl/noc_output_arbiter.sv
// Round-robin, packet-locking arbiter for one router output port with
// credit-based flow control toward the downstream FIFO.
//
// state  | meaning
// IDLE   | no owner; scan eligible HEADER requests from ptr+1
// ACTIVE | one channel locked to the output until its TAIL transfers

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module noc_output_arbiter #(
  parameter int CREDITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  req,
  input  logic [4:0]  empty_in,
  input  logic [14:0] flit_id_in,
  input  logic        credit_in,
  output logic [4:0]  grant,
  output logic [2:0]  xbar_sel,
  output logic [4:0]  read_en,
  output logic        valid_out,
  output logic [2:0]  credit_cnt
);

  localparam logic [2:0] CRED_MAX = 3'(CREDITS);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  grant_nxt;
  logic [2:0]  sel_nxt;
  logic [2:0]  ptr, ptr_nxt;
  logic [2:0]  credit_nxt;
  logic [4:0]  eligible;
  logic [2:0]  winner;
  logic        win_found;
  logic [3:0]  scan_idx;
  logic [2:0]  cur_id;
  logic        xfer;
  logic        tail_xfer;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < 5; i++) begin
      eligible[i] = req[i] & ~empty_in[i] & (flit_id_in[3*i +: 3] == `HEADER);
    end
  end

  // First eligible channel after the last winner, wrapping modulo 5.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int d = 1; d <= 5; d++) begin
      scan_idx = {1'b0, ptr} + 4'(d);
      if (scan_idx >= 4'd5) scan_idx = scan_idx - 4'd5;
      if (!win_found && eligible[scan_idx[2:0]]) begin
        win_found = 1'b1;
        winner    = scan_idx[2:0];
      end
    end
  end

  always_comb begin
    cur_id = '0;
    case (xbar_sel)
      3'd0:    cur_id = flit_id_in[2:0];
      3'd1:    cur_id = flit_id_in[5:3];
      3'd2:    cur_id = flit_id_in[8:6];
      3'd3:    cur_id = flit_id_in[11:9];
      3'd4:    cur_id = flit_id_in[14:12];
      default: cur_id = '0;
    endcase
  end

  // grant is one-hot, so masking by ~empty_in pops only the owner.
  always_comb begin
    read_en = '0;
    if (state == ACTIVE && credit_cnt != 3'd0) read_en = grant & ~empty_in;
  end

  assign xfer      = |read_en;
  assign valid_out = xfer;
  assign tail_xfer = xfer & (cur_id == `TAIL);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    sel_nxt   = xbar_sel;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        sel_nxt   = '0;
        if (win_found) begin
          state_nxt = ACTIVE;
          grant_nxt = 5'b00001 << winner;
          sel_nxt   = winner;
          ptr_nxt   = winner;
        end
      end
      ACTIVE: begin
        if (tail_xfer) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          sel_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        sel_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    credit_nxt = credit_cnt;
    case ({xfer, credit_in})
      2'b10:   credit_nxt = credit_cnt - 3'd1;
      2'b01:   if (credit_cnt < CRED_MAX) credit_nxt = credit_cnt + 3'd1;
      default: credit_nxt = credit_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      xbar_sel   <= '0;
      ptr        <= 3'd4;
      credit_cnt <= CRED_MAX;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      xbar_sel   <= sel_nxt;
      ptr        <= ptr_nxt;
      credit_cnt <= credit_nxt;
    end
  end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: directed scenarios on CREDITS=4 and CREDITS=2
// instances plus a randomized run against a packet-level reference model.

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module tb_noc_output_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  req = '0;
  logic [4:0]  empty_in = '1;
  logic [14:0] flit_id_in = '0;
  logic        credit_in = 1'b0;

  logic [4:0] g4, re4, g2, re2;
  logic [2:0] s4, c4, s2, c2;
  logic       v4, v2;

  int checks = 0;
  int errors = 0;

  logic [2:0] q [5][$];
  logic [4:0] req_v = '0;
  logic       sel2 = 1'b0;

  always #5 clk = ~clk;

  noc_output_arbiter #(.CREDITS(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .empty_in(empty_in), .flit_id_in(flit_id_in),
    .credit_in(credit_in), .grant(g4), .xbar_sel(s4), .read_en(re4),
    .valid_out(v4), .credit_cnt(c4));

  noc_output_arbiter #(.CREDITS(2)) dut2 (
    .clk(clk), .rst(rst), .req(req), .empty_in(empty_in), .flit_id_in(flit_id_in),
    .credit_in(credit_in), .grant(g2), .xbar_sel(s2), .read_en(re2),
    .valid_out(v2), .credit_cnt(c2));

  // Packet-level model: owner channel (-1 idle), last winner, free credits.
  int m_owner [2] = '{-1, -1};
  int m_last  [2] = '{4, 4};
  int m_cred  [2] = '{4, 2};
  int m_cap   [2] = '{4, 2};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_owner[k] = -1;
        m_last[k]  = 4;
        m_cred[k]  = m_cap[k];
      end else begin
        bit moved, last_flit, found;
        moved = (m_owner[k] >= 0) && !empty_in[m_owner[k]] && (m_cred[k] > 0);
        last_flit = moved && (flit_id_in[3*m_owner[k] +: 3] == `TAIL);
        if (moved && !credit_in) m_cred[k] = m_cred[k] - 1;
        else if (!moved && credit_in && m_cred[k] < m_cap[k]) m_cred[k] = m_cred[k] + 1;
        if (m_owner[k] < 0) begin
          found = 0;
          for (int d = 1; d <= 5; d++) begin
            int c;
            c = (m_last[k] + d) % 5;
            if (!found && req[c] && !empty_in[c] && flit_id_in[3*c +: 3] == `HEADER) begin
              found = 1;
              m_owner[k] = c;
              m_last[k]  = c;
            end
          end
        end else if (last_flit) begin
          m_owner[k] = -1;
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < 5; i++) begin
      empty_in[i] = (q[i].size() == 0);
      flit_id_in[3*i +: 3] = (q[i].size() == 0) ? 3'b000 : q[i][0];
    end
    req = req_v;
  endtask

  // One clock: present inputs, take the edge, pop what the selected DUT read.
  task automatic cyc();
    logic [4:0] re;
    drive();
    #1;
    re = sel2 ? re2 : re4;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++)
      if (re[i] && q[i].size() > 0) void'(q[i].pop_front());
    drive();
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 5; i++) q[i].delete();
    req_v = '0;
    credit_in = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (g4 !== 5'b0) begin errors++; $display("FAIL reset_grant: got %b want 00000", g4); end
    checks++; if (s4 !== 3'd0) begin errors++; $display("FAIL reset_xbar_sel: got %0d want 0", s4); end
    checks++; if (c4 !== 3'd4) begin errors++; $display("FAIL reset_credit4: got %0d want 4", c4); end
    checks++; if (c2 !== 3'd2) begin errors++; $display("FAIL reset_credit2: got %0d want 2", c2); end
    checks++; if (re4 !== 5'b0 || v4 !== 1'b0) begin errors++; $display("FAIL reset_read_en: got %b/%b want 00000/0", re4, v4); end
  endtask

  task automatic test_single_packet();
    logic [2:0] exp_c [3] = '{3'd4, 3'd3, 3'd2};
    do_reset();
    sel2 = 1'b0;
    q[4].push_back(`HEADER); q[4].push_back(`PAYLOAD); q[4].push_back(`TAIL);
    req_v = 5'b10000;
    for (int n = 0; n < 3; n++) begin
      cyc();
      checks++; if (g4 !== 5'b10000 || s4 !== 3'd4) begin errors++; $display("FAIL single_grant[%0d]: got %b/%0d want 10000/4", n, g4, s4); end
      checks++; if (re4 !== 5'b10000 || v4 !== 1'b1) begin errors++; $display("FAIL single_read_en[%0d]: got %b/%b want 10000/1", n, re4, v4); end
      checks++; if (c4 !== exp_c[n]) begin errors++; $display("FAIL single_credit[%0d]: got %0d want %0d", n, c4, exp_c[n]); end
    end
    cyc();
    checks++; if (g4 !== 5'b0 || s4 !== 3'd0) begin errors++; $display("FAIL single_release: got %b/%0d want 00000/0", g4, s4); end
    checks++; if (c4 !== 3'd1) begin errors++; $display("FAIL single_credit_end: got %0d want 1", c4); end
    req_v = '0;
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_rr [17] = '{5'b00001, 5'b00001, 5'b0, 5'b00010, 5'b00010, 5'b0,
                                5'b01000, 5'b01000, 5'b0, 5'b00001, 5'b00001, 5'b0,
                                5'b00010, 5'b00010, 5'b0, 5'b01000, 5'b01000};
    do_reset();
    sel2 = 1'b0;
    credit_in = 1'b1;
    for (int p = 0; p < 2; p++) begin
      q[0].push_back(`HEADER); q[0].push_back(`TAIL);
      q[1].push_back(`HEADER); q[1].push_back(`TAIL);
      q[3].push_back(`HEADER); q[3].push_back(`TAIL);
    end
    req_v = 5'b01011;
    for (int n = 0; n < 17; n++) begin
      cyc();
      checks++; if (g4 !== exp_rr[n]) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", n, g4, exp_rr[n]); end
    end
    checks++; if (c4 !== 3'd4) begin errors++; $display("FAIL rr_credit: got %0d want 4", c4); end
    credit_in = 1'b0;
    req_v = '0;
  endtask

  task automatic test_packet_lock();
    do_reset();
    sel2 = 1'b0;
    credit_in = 1'b1;
    q[1].push_back(`HEADER); q[1].push_back(`PAYLOAD); q[1].push_back(`PAYLOAD); q[1].push_back(`TAIL);
    req_v = 5'b00010;
    cyc();
    checks++; if (g4 !== 5'b00010) begin errors++; $display("FAIL lock_first: got %b want 00010", g4); end
    q[0].push_back(`HEADER); q[0].push_back(`TAIL);
    req_v = 5'b00011;
    for (int n = 0; n < 3; n++) begin
      cyc();
      checks++; if (g4 !== 5'b00010) begin errors++; $display("FAIL lock_hold[%0d]: got %b want 00010", n, g4); end
    end
    cyc();
    checks++; if (g4 !== 5'b0) begin errors++; $display("FAIL lock_gap: got %b want 00000", g4); end
    cyc();
    checks++; if (g4 !== 5'b00001 || s4 !== 3'd0) begin errors++; $display("FAIL lock_next: got %b/%0d want 00001/0", g4, s4); end
    credit_in = 1'b0;
    req_v = '0;
  endtask

  task automatic test_credit_stall();
    logic [2:0] exp_sat [4] = '{3'd1, 3'd2, 3'd2, 3'd2};
    do_reset();
    sel2 = 1'b1;
    q[2].push_back(`HEADER); q[2].push_back(`PAYLOAD); q[2].push_back(`PAYLOAD); q[2].push_back(`TAIL);
    req_v = 5'b00100;
    cyc();
    checks++; if (g2 !== 5'b00100 || re2 !== 5'b00100 || c2 !== 3'd2) begin errors++; $display("FAIL stall_c1: got %b/%b/%0d want 00100/00100/2", g2, re2, c2); end
    cyc();
    checks++; if (re2 !== 5'b00100 || c2 !== 3'd1) begin errors++; $display("FAIL stall_c2: got %b/%0d want 00100/1", re2, c2); end
    for (int n = 0; n < 3; n++) begin
      cyc();
      checks++; if (g2 !== 5'b00100 || re2 !== 5'b0 || v2 !== 1'b0 || c2 !== 3'd0) begin errors++; $display("FAIL stall_bubble[%0d]: got %b/%b/%b/%0d want 00100/00000/0/0", n, g2, re2, v2, c2); end
    end
    credit_in = 1'b1;
    cyc();
    checks++; if (re2 !== 5'b00100 || c2 !== 3'd1) begin errors++; $display("FAIL stall_release: got %b/%0d want 00100/1", re2, c2); end
    cyc();
    checks++; if (re2 !== 5'b00100 || c2 !== 3'd1) begin errors++; $display("FAIL stall_simul: got %b/%0d want 00100/1", re2, c2); end
    credit_in = 1'b0;
    cyc();
    checks++; if (g2 !== 5'b0 || c2 !== 3'd0) begin errors++; $display("FAIL stall_tail: got %b/%0d want 00000/0", g2, c2); end
    req_v = '0;
    credit_in = 1'b1;
    for (int n = 0; n < 4; n++) begin
      cyc();
      checks++; if (c2 !== exp_sat[n]) begin errors++; $display("FAIL stall_saturate[%0d]: got %0d want %0d", n, c2, exp_sat[n]); end
    end
    credit_in = 1'b0;
    sel2 = 1'b0;
  endtask

  task automatic test_eligibility();
    do_reset();
    sel2 = 1'b0;
    q[2].push_back(`PAYLOAD);
    req_v = 5'b00100;
    for (int n = 0; n < 3; n++) begin
      cyc();
      checks++; if (g4 !== 5'b0) begin errors++; $display("FAIL elig_payload[%0d]: got %b want 00000", n, g4); end
    end
    q[2].delete();
    for (int n = 0; n < 2; n++) begin
      cyc();
      checks++; if (g4 !== 5'b0) begin errors++; $display("FAIL elig_empty[%0d]: got %b want 00000", n, g4); end
    end
    q[2].push_back(`HEADER); q[2].push_back(`TAIL);
    cyc();
    checks++; if (g4 !== 5'b00100 || s4 !== 3'd2) begin errors++; $display("FAIL elig_header: got %b/%0d want 00100/2", g4, s4); end
    cyc();
    cyc();
    req_v = '0;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    sel2 = 1'b0;
    q[3].push_back(`HEADER); q[3].push_back(`PAYLOAD); q[3].push_back(`PAYLOAD); q[3].push_back(`TAIL);
    req_v = 5'b01000;
    cyc();
    cyc();
    checks++; if (g4 !== 5'b01000 || re4 !== 5'b01000) begin errors++; $display("FAIL midrst_pre: got %b/%b want 01000/01000", g4, re4); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++; if (g4 !== 5'b0 || s4 !== 3'd0 || re4 !== 5'b0) begin errors++; $display("FAIL midrst_clear: got %b/%0d/%b want 00000/0/00000", g4, s4, re4); end
    checks++; if (c4 !== 3'd4 || c2 !== 3'd2) begin errors++; $display("FAIL midrst_credit: got %0d/%0d want 4/2", c4, c2); end
    for (int i = 0; i < 5; i++) q[i].delete();
    q[0].push_back(`HEADER); q[0].push_back(`TAIL);
    q[3].push_back(`HEADER); q[3].push_back(`TAIL);
    req_v = 5'b01001;
    cyc();
    checks++; if (g4 !== 5'b00001 || g2 !== 5'b00001) begin errors++; $display("FAIL midrst_first: got %b/%b want 00001/00001", g4, g2); end
    req_v = '0;
  endtask

  task automatic test_random();
    logic [2:0] ids [4] = '{`HEADER, `PAYLOAD, `TAIL, 3'b000};
    logic [4:0] dg [2];
    logic [4:0] dre [2];
    logic [2:0] ds [2];
    logic [2:0] dc [2];
    logic [4:0] eg, ere;
    logic [2:0] es;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      req = 5'($urandom);
      for (int i = 0; i < 5; i++) begin
        empty_in[i] = ($urandom_range(0, 3) == 0);
        flit_id_in[3*i +: 3] = ids[$urandom_range(0, 3)];
      end
      credit_in = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 149) == 0);
      #1;
      dg[0] = g4; dre[0] = re4; ds[0] = s4; dc[0] = c4;
      dg[1] = g2; dre[1] = re2; ds[1] = s2; dc[1] = c2;
      for (int k = 0; k < 2; k++) begin
        eg  = (m_owner[k] >= 0) ? 5'(1 << m_owner[k]) : 5'b0;
        es  = (m_owner[k] >= 0) ? 3'(m_owner[k]) : 3'd0;
        ere = (m_owner[k] >= 0 && !empty_in[m_owner[k]] && m_cred[k] > 0) ? eg : 5'b0;
        checks++; if (dg[k] !== eg || ds[k] !== es) begin errors++; $display("FAIL rand_grant[%0d] inst%0d: got %b/%0d want %b/%0d", n, k, dg[k], ds[k], eg, es); end
        checks++; if (dre[k] !== ere) begin errors++; $display("FAIL rand_read_en[%0d] inst%0d: got %b want %b", n, k, dre[k], ere); end
        checks++; if (dc[k] !== 3'(m_cred[k])) begin errors++; $display("FAIL rand_credit[%0d] inst%0d: got %0d want %0d", n, k, dc[k], m_cred[k]); end
      end
      checks++; if (v4 !== (|re4) || v2 !== (|re2)) begin errors++; $display("FAIL rand_valid[%0d]: got %b/%b want %b/%b", n, v4, v2, |re4, |re2); end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    credit_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_packet_lock();
    test_credit_stall();
    test_eligibility();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_output_arbiter.md
# noc_output_arbiter

- Round-robin, packet-locking arbiter for one router output port.
- Five input channels (N, E, W, S, L) request the port through their LBDR port bits; the arbiter grants one channel at a time.
- The grant is held from the HEADER flit until that channel's TAIL flit has been transferred.
- Transfers are paced by a credit counter that tracks free slots in the downstream FIFO. One instance sits behind each router output, beside the crossbar.

## Interface
Parameters:
- CREDITS, 4: downstream buffer depth, which is also the credit counter reset value (1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- req  in  5  request per input channel, from that channel's LBDR port bit; index 0=N, 1=E, 2=W, 3=S, 4=L.
- empty_in  in  5  input FIFO empty flag per channel.
- flit_id_in  in  15  head-flit id per channel, 3 bits each; channel i occupies [3i+2:3i]. Encodings are the `HEADER/`PAYLOAD/`TAIL macros from parameters.sv.
- credit_in  in  1  one-cycle pulse meaning the downstream FIFO freed one slot.
- grant  out  5  registered one-hot grant, or 0 when idle.
- xbar_sel  out  3  registered binary index of the granted channel (0..4), or 0 when idle.
- read_en  out  5  combinational pop strobe to the granted input FIFO.
- valid_out  out  1  combinational; equals |read_en, and marks a flit crossing the crossbar this cycle.
- credit_cnt  out  3  registered count of available downstream slots.

## Operation
- State machine has two states, IDLE and ACTIVE. Reset enters IDLE.
- Channel i is eligible in IDLE when all three hold: req[i]=1, empty_in[i]=0, and flit_id of channel i = `HEADER.
- IDLE behaviour:
  - If any channel is eligible, choose the first eligible index scanning upward from ptr+1 modulo 5.
  - Register grant (one-hot) and xbar_sel, set ptr to the winner, and go to ACTIVE.
  - Otherwise stay in IDLE with grant=0.
- ACTIVE behaviour:
  - read_en[w] = grant[w] & ~empty_in[w] & (credit_cnt != 0), where w is the granted channel.
  - A transfer happens in any cycle where read_en is nonzero.
  - If the transferred flit's id is `TAIL, then next cycle grant=0, xbar_sel=0, and the state returns to IDLE.
- Lock rules:
  - Changes on req are ignored while ACTIVE; the lock holds until TAIL.
  - Non-HEADER head flits never win arbitration.
- Credit counter:
  - Decrements by 1 on each transfer and increments by 1 on each credit_in pulse.
  - A transfer and a credit_in in the same cycle leave it unchanged.
  - It saturates at CREDITS; an extra credit_in at CREDITS is ignored.
  - read_en is never asserted at 0, so underflow is impossible.
- ptr resets to 4, so N (index 0) has first priority after reset.
- In IDLE, read_en = 0 and valid_out = 0.
- Reset mid-packet:
  - grant=0, xbar_sel=0, read_en=0, state=IDLE, ptr=4, credit_cnt=CREDITS.
  - The partial packet is abandoned; recovery is handled above this block.
- Reset values: grant 0, xbar_sel 0, credit_cnt CREDITS, read_en 0, valid_out 0.

## Timing
- Arbitration latency:
  - An eligible request sampled at edge n gives grant at n+1.
  - The first read_en is in the same cycle n+1 if credit_cnt>0 and the FIFO is not empty.
- A packet of L flits with no stalls takes grant cycles n+1..n+L, with one flit per cycle.
- Release:
  - A TAIL transferred in cycle m gives grant=0 in m+1.
  - The next grant is at m+2 at the earliest, so there is one idle arbitration cycle between packets.
- Stalls:
  - An empty input FIFO or credit_cnt=0 inserts bubbles, with grant held.
  - A credit_in arriving while credit_cnt=0 lets read_en assert in the following cycle.
- Only one credit_in is counted per cycle.

## Test plan
- Single packet: after reset, channel L requests with a 3-flit packet (HEADER, PAYLOAD, TAIL).
  - grant=5'b10000 and xbar_sel=4 one cycle later.
  - read_en[4] asserts for 3 consecutive cycles, credit_cnt goes 4→1, and grant=0 the cycle after TAIL.
- Round-robin fairness: N, E and S all request continuously with 2-flit packets.
  - Grant order is N, E, S, N, E, S, with one idle cycle between packets.
- Packet locking: E is granted and mid-packet N raises req.
  - grant stays 5'b00010 until E's TAIL; N is granted next.
- Credit stall: CREDITS=2, W sends a 4-flit packet, and credit_in is held 0 for the first 5 cycles.
  - Two flits transfer, then read_en=0 with grant held.
  - Single credit_in pulses release one flit each; simultaneous transfer and credit_in keep credit_cnt constant.
  - credit_in pulses at credit_cnt=CREDITS leave it at CREDITS.
- Eligibility: req[2]=1 with flit_id=`PAYLOAD at head, or with empty_in[2]=1.
  - No grant is issued; W is granted one cycle after its HEADER appears.
- Reset mid-packet: assert rst during S's PAYLOAD.
  - Next cycle: grant=0, read_en=0, credit_cnt=CREDITS.
  - The first grant after reset goes to N when N and S both request.
